// File: rtl/dmi_slave_adapter.sv
// DMI responder: turns one DMI request at a time into a single req/gnt, rvalid/rdata
// register-bus access and returns the DMI response, with an optional access timeout.
module dmi_slave_adapter #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // {addr[6:0], op[1:0], data[31:0]}
    input  logic [40:0] dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    // {data[31:0], resp[1:0]}
    output logic [33:0] dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [6:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_gnt_i,
    input  logic        reg_rvalid_i,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_err_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    localparam logic [1:0] RespSuccess = 2'd0;
    localparam logic [1:0] RespFailed  = 2'd2;

    // A zero timeout still gets a 1-bit counter so the compare stays well formed.
    localparam int unsigned   CntW   = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [6:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_code_q, rsp_code_d;

    logic              timeout_hit;
    logic [CntW-1:0]   cnt_inc;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_code_d = rsp_code_q;

        timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntMax);
        // Saturate at the timeout value so a grant on the last cycle still leaves WAIT bounded.
        cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (dmi_req_valid_i) begin
                    addr_d  = dmi_req_i[40:34];
                    op_d    = op_e'(dmi_req_i[33:32]);
                    wdata_d = dmi_req_i[31:0];
                    cnt_d   = '0;
                    unique case (op_e'(dmi_req_i[33:32]))
                        OP_NOP: begin
                            rsp_data_d = '0;
                            rsp_code_d = RespSuccess;
                            state_d    = RESP;
                        end
                        OP_RSVD: begin
                            rsp_data_d = '0;
                            rsp_code_d = RespFailed;
                            state_d    = RESP;
                        end
                        default: state_d = ACCESS;
                    endcase
                end
            end
            ACCESS: begin
                cnt_d = cnt_inc;
                if (reg_gnt_i) begin
                    state_d = WAIT;
                end else if (timeout_hit) begin
                    rsp_data_d = '0;
                    rsp_code_d = RespFailed;
                    state_d    = RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (reg_rvalid_i) begin
                    rsp_data_d = (op_q == OP_READ) ? reg_rdata_i : '0;
                    rsp_code_d = reg_err_i ? RespFailed : RespSuccess;
                    state_d    = RESP;
                end else if (timeout_hit) begin
                    rsp_data_d = '0;
                    rsp_code_d = RespFailed;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (dmi_resp_ready_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= OP_NOP;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_code_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_code_q <= rsp_code_d;
        end
    end

    // Outputs decode registered state only; reset forces them quiet in the reset cycle itself.
    always_comb begin
        dmi_req_ready_o  = !rst_i && (state_q == IDLE);
        dmi_resp_valid_o = !rst_i && (state_q == RESP);
        reg_req_o        = !rst_i && (state_q == ACCESS);
        reg_we_o         = !rst_i && (state_q == ACCESS) && (op_q == OP_WRITE);
        reg_addr_o       = rst_i ? '0 : addr_q;
        reg_wdata_o      = rst_i ? '0 : wdata_q;
        busy_o           = !rst_i && (state_q != IDLE);
        dmi_resp_o       = {rsp_data_q, rsp_code_q};
    end

endmodule

// File: tb/tb_dmi_slave_adapter.sv
// Scoreboard bench for dmi_slave_adapter: a driver issues requests and plays the register
// slave, a monitor compares every presented DMI response against the queued expectation.
module tb_dmi_slave_adapter;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [40:0] dmi_req_i;
    logic        dmi_req_valid_i;
    logic        dmi_req_ready_o;
    logic [33:0] dmi_resp_o;
    logic        dmi_resp_valid_o;
    logic        dmi_resp_ready_i;
    logic        reg_req_o;
    logic        reg_we_o;
    logic [6:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_gnt_i;
    logic        reg_rvalid_i;
    logic [31:0] reg_rdata_i;
    logic        reg_err_i;
    logic        busy_o;

    dmi_slave_adapter #(.TimeoutCycles(T)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .dmi_req_i        (dmi_req_i),
        .dmi_req_valid_i  (dmi_req_valid_i),
        .dmi_req_ready_o  (dmi_req_ready_o),
        .dmi_resp_o       (dmi_resp_o),
        .dmi_resp_valid_o (dmi_resp_valid_o),
        .dmi_resp_ready_i (dmi_resp_ready_i),
        .reg_req_o        (reg_req_o),
        .reg_we_o         (reg_we_o),
        .reg_addr_o       (reg_addr_o),
        .reg_wdata_o      (reg_wdata_o),
        .reg_gnt_i        (reg_gnt_i),
        .reg_rvalid_i     (reg_rvalid_i),
        .reg_rdata_i      (reg_rdata_i),
        .reg_err_i        (reg_err_i),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hold_rdy = 0;
    bit   in_resp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: also drives response back-pressure so handshake and comparison see the same ready.
    initial begin
        logic nr;
        dmi_resp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_rdy > 0 && dmi_resp_valid_o) begin
                nr = 1'b0;
                hold_rdy--;
            end else begin
                nr = ($urandom_range(0, 3) != 0);
            end
            dmi_resp_ready_i = nr;
            if (dmi_resp_valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 64'(dmi_resp_valid_o), 64'd0);
                end else begin
                    if (!in_resp) check("resp_cycle", 64'(cyc), 64'(sb[0].cyc));
                    check("resp_data", 64'(dmi_resp_o[33:2]), 64'(sb[0].data));
                    check("resp_code", 64'(dmi_resp_o[1:0]), 64'(sb[0].resp));
                    check("req_ready_while_resp", 64'(dmi_req_ready_o), 64'd0);
                    in_resp = 1'b1;
                    if (nr) begin
                        void'(sb.pop_front());
                        in_resp = 1'b0;
                    end
                end
            end
        end
    end

    task automatic accept(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                          output int unsigned t);
        int n;
        @(negedge clk);
        dmi_req_i       = {addr, op, data};
        dmi_req_valid_i = 1'b1;
        n = 0;
        while (!dmi_req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("req_accept_timeout", 64'(dmi_req_ready_o), 64'd1);
        t = cyc;
    endtask

    task automatic release_req();
        @(posedge clk);
        #1;
        dmi_req_valid_i = 1'b0;
        dmi_req_i       = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("resp_never_seen", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    // One transaction: the slave grants kg cycles into ACCESS and answers jr cycles into WAIT.
    task automatic run_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                           input int unsigned kg, input int unsigned jr,
                           input logic [31:0] rdata, input logic err);
        int unsigned t, ir, last, acc_end;
        bit rw, ok;
        exp_t e;
        rw = (op == 2'd1) || (op == 2'd2);
        ir = kg + 1 + jr;
        ok = (kg <= T) && ((ir <= T) || (jr == 0));
        acc_end = (kg < T) ? kg : T;
        accept(op, addr, data, t);
        if (!rw) begin
            e.data = '0;
            e.resp = (op == 2'd3) ? 2'd2 : 2'd0;
            e.cyc  = t + 1;
        end else begin
            e.data = (ok && op == 2'd1) ? rdata : 32'd0;
            e.resp = ok ? (err ? 2'd2 : 2'd0) : 2'd2;
            e.cyc  = t + 2 + (ok ? ir : T);
        end
        sb.push_back(e);
        release_req();
        last = rw ? (((ir > T) ? ir : T) + 1) : 0;
        for (int unsigned idx = 0; idx <= last; idx++) begin
            bit exp_req;
            @(negedge clk);
            exp_req = rw && (idx <= acc_end);
            check("reg_req", 64'(reg_req_o), 64'(exp_req));
            if (idx == 0) check("busy", 64'(busy_o), 64'd1);
            if (exp_req) begin
                check("reg_we", 64'(reg_we_o), 64'(op == 2'd2));
                check("reg_addr", 64'(reg_addr_o), 64'(addr));
                check("reg_wdata", 64'(reg_wdata_o), 64'(data));
            end
            if (rw) begin
                reg_gnt_i    = (idx == kg);
                reg_rvalid_i = (idx == ir);
                reg_rdata_i  = (idx == ir) ? rdata : $urandom;
                reg_err_i    = (idx == ir) ? err : 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        reg_gnt_i    = 1'b0;
        reg_rvalid_i = 1'b0;
        drain();
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 64'(dmi_req_ready_o), 64'd0);
        check("rst_resp_valid", 64'(dmi_resp_valid_o), 64'd0);
        check("rst_reg_req", 64'(reg_req_o), 64'd0);
        check("rst_reg_we", 64'(reg_we_o), 64'd0);
        check("rst_reg_addr", 64'(reg_addr_o), 64'd0);
        check("rst_reg_wdata", 64'(reg_wdata_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
    endtask

    initial begin
        int unsigned t;
        rst_i           = 1'b1;
        dmi_req_i       = '0;
        dmi_req_valid_i = 1'b0;
        reg_gnt_i       = 1'b0;
        reg_rvalid_i    = 1'b0;
        reg_rdata_i     = '0;
        reg_err_i       = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_i = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(dmi_req_ready_o), 64'd1);

        // Happy read, error write with response back-pressure, NOP, reserved op.
        run_txn(2'd1, 7'h11, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
        hold_rdy = 3;
        run_txn(2'd2, 7'h10, 32'h1234_5678, 4, 0, 32'hCAFE_F00D, 1'b1);
        run_txn(2'd0, 7'h05, 32'hFFFF_FFFF, 0, 0, 32'h0, 1'b0);
        run_txn(2'd3, 7'h06, 32'hA5A5_A5A5, 0, 0, 32'h0, 1'b0);
        // Timeout with no grant (late grant/rvalid are strays), then a normal read.
        run_txn(2'd1, 7'h20, 32'h0, 20, 0, 32'h1111_2222, 1'b0);
        run_txn(2'd1, 7'h21, 32'h0, 1, 2, 32'h3333_4444, 1'b0);
        // Grant on the very cycle the counter reaches the limit wins over the timeout.
        run_txn(2'd1, 7'h22, 32'h0, T, 0, 32'h5555_6666, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int unsigned kg, jr;
            logic [1:0] op;
            op = ($urandom_range(0, 9) < 8) ? 2'(1 + $urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            kg = $urandom_range(0, T + 3);
            jr = (kg == T) ? 0 : $urandom_range(0, 4);
            run_txn(op, 7'($urandom), $urandom, kg, jr, $urandom, 1'($urandom_range(0, 3) == 0));
        end

        // Reset during WAIT abandons the access with no response.
        accept(2'd1, 7'h33, 32'h0, t);
        release_req();
        @(negedge clk);
        reg_gnt_i = 1'b1;
        @(negedge clk);
        reg_gnt_i = 1'b0;
        check("wait_busy", 64'(busy_o), 64'd1);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        check_reset_outputs();
        rst_i = 1'b0;
        @(negedge clk);
        check("ready_after_midreset", 64'(dmi_req_ready_o), 64'd1);
        check("busy_after_midreset", 64'(busy_o), 64'd0);
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = 32'hBAD0_BAD0;
        @(negedge clk);
        reg_rvalid_i = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_after_stray", 64'(busy_o), 64'd0);
        run_txn(2'd1, 7'h44, 32'h0, 2, 1, 32'h7777_8888, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
